// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full adder reused LSB-first over WIDTH cycles
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c_reg;
    logic [CW-1:0]    cnt;

    // Full adder built from two half adders and an OR.
    logic ha1_s, ha1_c, fa_s, ha2_c, fa_c;

    assign ha1_s = a_sh[0] ^ b_sh[0];
    assign ha1_c = a_sh[0] & b_sh[0];
    assign fa_s  = ha1_s ^ c_reg;
    assign ha2_c = ha1_s & c_reg;
    assign fa_c  = ha1_c | ha2_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            c_reg    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= opA;
                        b_sh  <= opB;
                        c_reg <= carryIn;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    // Sum bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    c_reg <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        carryOut <= fa_c;
                        overflow <= c_reg ^ fa_c;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
